// File: rtl/simd_vec_alu_pipe.sv
// simd_vec_alu_pipe
//   Two-stage pipelined SIMD vector ALU for the AES datapath. Each transaction
//   carries NUM_WORDS independent 32-bit words. Every word gets byte-wise
//   ADD/SUB, AND/OR/XOR, byte rotation, MixColumns or inverse MixColumns.
//   S1 captures the operands, and S2 holds the registered result. Flow control
//   is valid/ready on both sides.
// Ports
//   clk, rst            clock; synchronous active-high reset
//   in_valid/in_ready   input handshake (in_ready never depends on in_valid)
//   in_op               3-bit opcode
//   in_a, in_b          operand vectors, word i at [32*i +: 32]
//   in_mask             per-lane enable; 0 passes A word through
//   in_tag              sideband tag returned with the result
//   out_valid/out_ready output handshake
//   out_result, out_tag result vector and its tag
module simd_vec_alu_pipe #(
  parameter int NUM_WORDS = 4,
  parameter int TAG_W     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             in_op,
  input  logic [32*NUM_WORDS-1:0] in_a,
  input  logic [32*NUM_WORDS-1:0] in_b,
  input  logic [NUM_WORDS-1:0]   in_mask,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [32*NUM_WORDS-1:0] out_result,
  output logic [TAG_W-1:0]       out_tag
);

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_AND   = 3'b010,
    OP_OR    = 3'b011,
    OP_ROTW  = 3'b100,
    OP_MIXC  = 3'b101,
    OP_IMIXC = 3'b110,
    OP_XOR   = 3'b111
  } op_e;

  // Multiply by x in GF(2^8), reduction polynomial 0x11B
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // The packed byte index is 3-j for byte s_j (s0 is the MSB), which is ~j on 2 bits.
  // As a result, the (j+k) mod 4 neighbours of a column row come from 2-bit wrap arithmetic.
  function automatic logic [31:0] word_op(input op_e op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [3:0][7:0] sa, sb, r;
    logic [1:0]      j;
    logic [7:0]      x0, x1, x2, x3;
    logic [7:0]      x1_2, x2_2, x2_4, x3_2, x3_4;
    logic [7:0]      x0_2, x0_4, x0_8, x1_4, x1_8, x2_8, x3_8;
    sa = a;
    sb = b;
    r  = '0;
    unique case (op)
      OP_ADD: for (int unsigned i = 0; i < 4; i++) r[i] = sa[i] + sb[i];
      OP_SUB: for (int unsigned i = 0; i < 4; i++) r[i] = sa[i] - sb[i];
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_ROTW: begin
        unique case (b[1:0])
          2'd0: r = a;
          2'd1: r = {a[23:0], a[31:24]};
          2'd2: r = {a[15:0], a[31:16]};
          default: r = {a[7:0], a[31:8]};
        endcase
      end
      default: begin
        for (int unsigned i = 0; i < 4; i++) begin
          j    = 2'(i);
          x0   = sa[~j];
          x1   = sa[~(j + 2'd1)];
          x2   = sa[~(j + 2'd2)];
          x3   = sa[~(j + 2'd3)];
          x0_2 = xt(x0);  x0_4 = xt(x0_2);  x0_8 = xt(x0_4);
          x1_2 = xt(x1);  x1_4 = xt(x1_2);  x1_8 = xt(x1_4);
          x2_2 = xt(x2);  x2_4 = xt(x2_2);  x2_8 = xt(x2_4);
          x3_2 = xt(x3);  x3_4 = xt(x3_2);  x3_8 = xt(x3_4);
          if (op == OP_MIXC)
            // 2*s_j ^ 3*s_j+1 ^ s_j+2 ^ s_j+3
            r[~j] = x0_2 ^ (x1_2 ^ x1) ^ x2 ^ x3;
          else
            // 0e*s_j ^ 0b*s_j+1 ^ 0d*s_j+2 ^ 09*s_j+3
            r[~j] = (x0_8 ^ x0_4 ^ x0_2) ^ (x1_8 ^ x1_2 ^ x1) ^
                    (x2_8 ^ x2_4 ^ x2)   ^ (x3_8 ^ x3);
        end
      end
    endcase
    return r;
  endfunction

  logic                    r_s1_valid;
  op_e                     r_s1_op;
  logic [32*NUM_WORDS-1:0] r_s1_a, r_s1_b;
  logic [NUM_WORDS-1:0]    r_s1_mask;
  logic [TAG_W-1:0]        r_s1_tag;
  logic                    r_s2_valid;
  logic [32*NUM_WORDS-1:0] r_s2_result;
  logic [TAG_W-1:0]        r_s2_tag;

  logic                    w_s2_load;
  logic                    w_accept;
  logic [32*NUM_WORDS-1:0] w_result;

  assign w_s2_load = r_s1_valid && (!r_s2_valid || out_ready);
  assign in_ready  = !rst && (!r_s1_valid || w_s2_load);
  assign w_accept  = in_valid && in_ready;

  always_comb begin
    w_result = '0;
    for (int unsigned w = 0; w < NUM_WORDS; w++)
      w_result[32*w +: 32] = r_s1_mask[w] ? word_op(r_s1_op, r_s1_a[32*w +: 32],
                                                    r_s1_b[32*w +: 32])
                                          : r_s1_a[32*w +: 32];
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_s1_valid <= 1'b0;
    else if (w_accept)
      r_s1_valid <= 1'b1;
    else if (w_s2_load)
      r_s1_valid <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_s1_op   <= op_e'(in_op);
      r_s1_a    <= in_a;
      r_s1_b    <= in_b;
      r_s1_mask <= in_mask;
      r_s1_tag  <= in_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid  <= 1'b0;
      r_s2_result <= '0;
      r_s2_tag    <= '0;
    end else if (w_s2_load) begin
      r_s2_valid  <= 1'b1;
      r_s2_result <= w_result;
      r_s2_tag    <= r_s1_tag;
    end else if (out_ready) begin
      r_s2_valid  <= 1'b0;
    end
  end

  assign out_valid  = r_s2_valid;
  assign out_result = r_s2_result;
  assign out_tag    = r_s2_tag;

endmodule

// File: tb/tb_simd_vec_alu_pipe.sv
// tb_simd_vec_alu_pipe
//   Self-checking bench for simd_vec_alu_pipe. It uses directed vectors for the known AES
//   values plus randomized traffic. The expected results come from an arithmetic
//   GF(2^8) reference model and an in-order scoreboard queue.
module tb_simd_vec_alu_pipe;
  localparam int NW = 4;
  localparam int TW = 4;
  localparam int W  = 32 * NW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [2:0]    in_op;
  logic [W-1:0]  in_a, in_b;
  logic [NW-1:0] in_mask;
  logic [TW-1:0] in_tag;
  logic          out_valid, out_ready;
  logic [W-1:0]  out_result;
  logic [TW-1:0] out_tag;

  always #5 clk = ~clk;

  simd_vec_alu_pipe #(.NUM_WORDS(NW), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_mask(in_mask), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag)
  );

  typedef struct {
    logic [W-1:0]  res;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t         q[$];
  logic [W-1:0] cur_exp;
  int           n_pass = 0;
  int           n_fail = 0;
  int           n_total = 0;

  task automatic chk(input string name, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  function automatic int gmul(input int x, input int c);
    int p, r;
    p = x;
    r = 0;
    for (int k = 0; k < 4; k++) begin
      if (((c >> k) & 1) != 0) r = r ^ p;
      p = p * 2;
      if (p > 255) p = p ^ 'h11B;
    end
    return r;
  endfunction

  function automatic logic [31:0] ref_word(input int op, input logic [31:0] a,
                                           input logic [31:0] b);
    int          s[4], t[4], r[4], k;
    int          mc[4] = '{2, 3, 1, 1};
    int          im[4] = '{14, 11, 13, 9};
    logic [31:0] y;
    for (int j = 0; j < 4; j++) begin
      s[j] = int'((a >> (24 - 8*j)) & 32'hff);
      t[j] = int'((b >> (24 - 8*j)) & 32'hff);
      r[j] = 0;
    end
    case (op)
      0: for (int j = 0; j < 4; j++) r[j] = (s[j] + t[j]) % 256;
      1: for (int j = 0; j < 4; j++) r[j] = (s[j] - t[j] + 256) % 256;
      2: return a & b;
      3: return a | b;
      4: begin
        k = int'(b % 4);
        if (k == 0) return a;
        return (a << (8*k)) | (a >> (32 - 8*k));
      end
      5, 6: for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          r[i] = r[i] ^ gmul(s[j], (op == 5) ? mc[(j - i + 4) % 4] : im[(j - i + 4) % 4]);
      default: return a ^ b;
    endcase
    y = 0;
    for (int j = 0; j < 4; j++) y = y | (32'(r[j]) << (24 - 8*j));
    return y;
  endfunction

  function automatic logic [W-1:0] ref_vec(input int op, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic [NW-1:0] m);
    logic [W-1:0] v;
    v = a;
    for (int i = 0; i < NW; i++)
      if (m[i]) v[32*i +: 32] = ref_word(op, a[32*i +: 32], b[32*i +: 32]);
    return v;
  endfunction

  // One clock cycle; entered at the falling edge with the inputs already driven
  task automatic step(output logic acc);
    exp_t e;
    #1;
    chk("in_ready", in_ready, !rst && (q.size() < 2 || out_ready));
    acc = in_valid && in_ready && !rst;
    if (out_valid === 1'b1) begin
      if (q.size() == 0) chk("spurious_out_valid", out_valid, 0);
      else begin
        chk("out_result", out_result, q[0].res);
        chk("out_tag", out_tag, q[0].tag);
        if (out_ready) void'(q.pop_front());
      end
    end
    if (acc) begin
      e.res = cur_exp;
      e.tag = in_tag;
      q.push_back(e);
    end
    @(posedge clk);
    if (rst) q.delete();
    @(negedge clk);
  endtask

  task automatic send(input int op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [NW-1:0] m, input logic [TW-1:0] tag,
                      input logic [W-1:0] exp);
    logic acc;
    in_valid = 1'b1;
    in_op    = 3'(op);
    in_a     = a;
    in_b     = b;
    in_mask  = m;
    in_tag   = tag;
    cur_exp  = exp;
    acc      = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) step(acc);
    if (!acc) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    logic acc;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) step(acc);
    chk("drain_empty", q.size(), 0);
  endtask

  logic         acc;
  logic         saw_block;
  int           sent, cyc, op;
  logic [W-1:0] ra, rb;
  logic [NW-1:0] rm;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0;
    in_mask = '0; in_tag = '0; out_ready = 1'b1; cur_exp = '0;
    @(negedge clk);
    step(acc);
    step(acc);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_tag", out_tag, 0);

    // MixColumns test column, then exact latency check on an empty pipe
    send(5, {NW{32'hdb135345}}, '0, '1, 4'h1, {NW{32'h8e4da1bc}});
    #1 chk("latency_n+1_empty", out_valid, 0);
    step(acc);
    #1 chk("latency_n+2_valid", out_valid, 1);
    chk("t1_result", out_result, {NW{32'h8e4da1bc}});
    step(acc);

    send(6, {NW{32'h8e4da1bc}}, '0, '1, 4'h2, {NW{32'hdb135345}});
    send(5, {NW{32'hf20a225c}}, '0, '1, 4'h3, {NW{32'h9fdc589d}});
    send(0, {NW{32'hff7f0001}}, {NW{32'h01010101}}, '1, 4'h4, {NW{32'h00800102}});
    send(1, {NW{32'hff7fff01}}, {NW{32'h02000002}}, '1, 4'h5, {NW{32'hfd7fffff}});
    send(4, {NW{32'h11223344}}, {32'd3, 32'd2, 32'd1, 32'd0}, '1, 4'h6,
         {32'h44112233, 32'h33441122, 32'h22334411, 32'h11223344});
    send(4, {NW{32'h11223344}}, {NW{32'hfffffffd}}, '1, 4'h7, {NW{32'h22334411}});
    send(7, {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444},
         {NW{32'h0f0f0f0f}}, 4'b0101, 4'h8,
         {32'h11111111, 32'h2d2d2d2d, 32'h33333333, 32'h4b4b4b4b});
    send(5, {NW{32'hdb135345}}, '0, '0, 4'h9, {NW{32'hdb135345}});
    drain();

    // Six back-to-back transactions with a three-cycle consumer stall
    sent = 0; cyc = 0; saw_block = 1'b0;
    while (sent < 6 && cyc < 100) begin
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      op = int'($urandom_range(0, 7));
      in_valid = 1'b1; in_op = 3'(op); in_a = ra; in_b = rb; in_mask = '1;
      in_tag = 4'(sent);
      cur_exp = ref_vec(op, ra, rb, '1);
      out_ready = !(cyc >= 2 && cyc < 5);
      #1 if (!in_ready) saw_block = 1'b1;
      step(acc);
      if (acc) sent++;
      cyc++;
    end
    chk("t5_all_sent", sent, 6);
    chk("t5_in_ready_fell", saw_block, 1);
    drain();

    // Reset with two transactions held; neither may ever emerge
    out_ready = 1'b0;
    send(2, {NW{32'hdeadbeef}}, {NW{32'hf0f0f0f0}}, '1, 4'ha, {NW{32'hd0a0b0e0}});
    send(3, {NW{32'h12345678}}, {NW{32'h0f0f0f0f}}, '1, 4'hb, {NW{32'h1f3f5f7f}});
    chk("t6_held_two", q.size(), 2);
    rst = 1'b1; in_valid = 1'b1;
    step(acc);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("t6_out_valid", out_valid, 0);
    chk("t6_out_result", out_result, 0);
    chk("t6_out_tag", out_tag, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step(acc);
    send(7, {NW{32'ha5a5a5a5}}, {NW{32'h5a5a5a5a}}, '1, 4'hc, {NW{32'hffffffff}});
    drain();

    // Randomized traffic with random backpressure
    for (int i = 0; i < 300; i++) begin
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      rm = 4'($urandom);
      op = int'($urandom_range(0, 7));
      in_valid = ($urandom_range(0, 3) != 0); in_op = 3'(op);
      in_a = ra; in_b = rb; in_mask = rm; in_tag = 4'($urandom);
      cur_exp = ref_vec(op, ra, rb, rm);
      out_ready = ($urandom_range(0, 3) != 0);
      step(acc);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
